// File: rtl/mod_exp_pkg.sv
// Shared types and constants for the mod_exp Montgomery exponentiation block.
// Optional build macro: MODEXP_ODDN_CHK_EN (see mod_exp.sv).
package mod_exp_pkg;

    // Operand width; the Montgomery radix is R = 2^W.
    parameter int unsigned W      = 32;
    // Bit-index counter width, ceil(log2(W)) + 1.
    parameter int unsigned CW     = 6;
    // Width of an exponent bit index (0 .. W-1).
    parameter int unsigned IW     = CW - 1;
    // Cycles spent inside the multiplier core per product (W steps + final reduction).
    parameter int unsigned MM_LAT = 33;

    // Sequencer states.
    typedef enum logic [2:0] {
        StIdle,
        StPreM,
        StPreX,
        StLoopSqr,
        StLoopMul,
        StPost,
        StFin
    } state_e;

endpackage

// File: rtl/mod_exp_mm_core.sv
// Handshaked radix-2 Montgomery multiplier: Z = A * B * 2^-W mod N.
// Operands are latched on start_i, W shift-add steps run one per cycle, then one
// cycle applies the final conditional subtraction while done_o is high.
module mod_exp_mm_core
    import mod_exp_pkg::*;
(
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         start_i,
    input  logic [W-1:0] a_i,
    input  logic [W-1:0] b_i,
    input  logic [W-1:0] n_i,
    output logic [W-1:0] z_o,
    output logic         done_o
);

    // Two guard bits: the running sum stays below 4N.
    localparam int unsigned AW = W + 2;

    logic [W-1:0]  a_q, b_q, n_q;
    logic [AW-1:0] z_q, z_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          run_q, run_d;

    logic [AW-1:0] n_ext;
    logic [AW-1:0] sum_ab;
    logic [AW-1:0] sum_abn;
    logic [AW-1:0] z_red;
    logic          last;

    // Reduction cycle: all W steps have been applied.
    assign last  = run_q && (cnt_q == CW'(MM_LAT - 1));
    assign n_ext = {2'b00, n_q};

    // One Montgomery step plus the final >= N correction of the accumulator.
    always_comb begin
        sum_ab  = z_q + (a_q[cnt_q[IW-1:0]] ? {2'b00, b_q} : '0);
        sum_abn = sum_ab + (sum_ab[0] ? n_ext : '0);
        z_red   = (z_q >= n_ext) ? (z_q - n_ext) : z_q;
    end

    // Next-state for accumulator, step counter and run flag.
    always_comb begin
        z_d   = z_q;
        cnt_d = cnt_q;
        run_d = run_q;
        if (start_i) begin
            z_d   = '0;
            cnt_d = '0;
            run_d = 1'b1;
        end else if (last) begin
            z_d   = z_red;
            run_d = 1'b0;
        end else if (run_q) begin
            z_d   = sum_abn >> 1;
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Operand latches and accumulator state.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            a_q   <= '0;
            b_q   <= '0;
            n_q   <= '0;
            z_q   <= '0;
            cnt_q <= '0;
            run_q <= 1'b0;
        end else begin
            if (start_i) begin
                a_q <= a_i;
                b_q <= b_i;
                n_q <= n_i;
            end
            z_q   <= z_d;
            cnt_q <= cnt_d;
            run_q <= run_d;
        end
    end

    // Once reduced, z_q < N so z_red simply holds it until the next start.
    assign z_o    = z_red[W-1:0];
    assign done_o = last;

endmodule

// File: rtl/mod_exp.sv
// Modular exponentiation C = M^E mod N by left-to-right square-and-multiply,
// sequencing Montgomery products on mod_exp_mm_core. Caller supplies R2 = 2^(2W) mod N.
// Optional build macro MODEXP_ODDN_CHK_EN: adds err_o and rejects an even N or N <= 1.
module mod_exp
    import mod_exp_pkg::*;
(
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         start_i,
    input  logic [W-1:0] m_i,
    input  logic [W-1:0] e_i,
    input  logic [W-1:0] n_i,
    input  logic [W-1:0] r2_i,
    output logic         busy_o,
    output logic         done_o,
    output logic [W-1:0] c_o
`ifdef MODEXP_ODDN_CHK_EN
    ,
    output logic         err_o
`endif
);

    state_e        state_q, state_d;
    logic          issue_q, issue_d;

    logic [W-1:0]  m_q, e_q, n_q, r2_q;
    logic [W-1:0]  mm_q;   // M in Montgomery form
    logic [W-1:0]  xm_q;   // running result in Montgomery form
    logic [W-1:0]  c_q;
    logic [IW-1:0] idx_q;

    logic          accept;
    logic          ebit;
    logic          idx_zero;

    logic          mm_start;
    logic [W-1:0]  mm_a, mm_b, mm_z;
    logic          mm_done;

`ifdef MODEXP_ODDN_CHK_EN
    logic          err_q;
    logic          n_ok;
    assign n_ok = n_q[0] && (n_q != W'(1));
`endif

    assign accept   = (state_q == StIdle) && start_i;
    assign ebit     = e_q[idx_q];
    assign idx_zero = (idx_q == '0);

    // State register; issue_q marks the first cycle of each product state.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= StIdle;
            issue_q <= 1'b0;
        end else begin
            state_q <= state_d;
            issue_q <= issue_d;
        end
    end

    // Next-state: every product state advances on the multiplier's done pulse.
    always_comb begin
        state_d = state_q;
        issue_d = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (start_i) begin
                    state_d = StPreM;
                    issue_d = 1'b1;
                end
            end
            StPreM: begin
`ifdef MODEXP_ODDN_CHK_EN
                if (!n_ok) begin
                    state_d = StFin;
                end else
`endif
                if (mm_done) begin
                    state_d = StPreX;
                    issue_d = 1'b1;
                end
            end
            StPreX: begin
                if (mm_done) begin
                    state_d = StLoopSqr;
                    issue_d = 1'b1;
                end
            end
            StLoopSqr: begin
                if (mm_done) begin
                    issue_d = 1'b1;
                    if (ebit) begin
                        state_d = StLoopMul;
                    end else if (idx_zero) begin
                        state_d = StPost;
                    end else begin
                        state_d = StLoopSqr;
                    end
                end
            end
            StLoopMul: begin
                if (mm_done) begin
                    issue_d = 1'b1;
                    state_d = idx_zero ? StPost : StLoopSqr;
                end
            end
            StPost: begin
                if (mm_done) begin
                    state_d = StFin;
                end
            end
            StFin: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // Outputs and multiplier operand selection per state.
    always_comb begin
        busy_o   = (state_q != StIdle);
        done_o   = (state_q == StFin);
        mm_start = issue_q;
`ifdef MODEXP_ODDN_CHK_EN
        // A rejected modulus never reaches the multiplier.
        mm_start = issue_q && n_ok;
`endif
        mm_a = xm_q;
        mm_b = xm_q;
        unique case (state_q)
            StPreM: begin
                mm_a = m_q;
                mm_b = r2_q;
            end
            StPreX: begin
                mm_a = W'(1);
                mm_b = r2_q;
            end
            StLoopMul: begin
                mm_b = mm_q;
            end
            StPost: begin
                mm_b = W'(1);
            end
            default: begin
            end
        endcase
    end

    // Operand latch, product capture and exponent bit index.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            m_q   <= '0;
            e_q   <= '0;
            n_q   <= '0;
            r2_q  <= '0;
            mm_q  <= '0;
            xm_q  <= '0;
            c_q   <= '0;
            idx_q <= '0;
`ifdef MODEXP_ODDN_CHK_EN
            err_q <= 1'b0;
`endif
        end else begin
            if (accept) begin
                m_q   <= m_i;
                e_q   <= e_i;
                n_q   <= n_i;
                r2_q  <= r2_i;
                idx_q <= IW'(W - 1);
`ifdef MODEXP_ODDN_CHK_EN
                err_q <= 1'b0;
`endif
            end
            if (mm_done) begin
                case (state_q)
                    StPreM:                       mm_q <= mm_z;
                    StPreX, StLoopSqr, StLoopMul: xm_q <= mm_z;
                    StPost:                       c_q  <= mm_z;
                    default: begin
                    end
                endcase
                // Move to the next exponent bit once this bit's work is finished.
                if (((state_q == StLoopSqr && !ebit) || state_q == StLoopMul) && !idx_zero) begin
                    idx_q <= idx_q - 1'b1;
                end
            end
`ifdef MODEXP_ODDN_CHK_EN
            if (state_q == StPreM && !n_ok) begin
                c_q   <= '0;
                err_q <= 1'b1;
            end
`endif
        end
    end

    assign c_o = c_q;
`ifdef MODEXP_ODDN_CHK_EN
    assign err_o = err_q;
`endif

    mod_exp_mm_core u_mm_core (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .start_i (mm_start),
        .a_i     (mm_a),
        .b_i     (mm_b),
        .n_i     (n_q),
        .z_o     (mm_z),
        .done_o  (mm_done)
    );

endmodule

// File: tb/tb_mod_exp.sv
// Self-checking bench for mod_exp: directed cases, control scenarios and random
// operands checked against a plain-arithmetic modular exponentiation model.
module tb_mod_exp;
    import mod_exp_pkg::*;

    logic         clk_i = 1'b0;
    logic         rst_ni;
    logic         start_i;
    logic [W-1:0] m_i, e_i, n_i, r2_i;
    logic         busy_o, done_o;
    logic [W-1:0] c_o;
`ifdef MODEXP_ODDN_CHK_EN
    logic         err_o;
`endif

    int checks   = 0;
    int failures = 0;

    always #5 clk_i = ~clk_i;

    mod_exp dut (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .start_i (start_i),
        .m_i     (m_i),
        .e_i     (e_i),
        .n_i     (n_i),
        .r2_i    (r2_i),
        .busy_o  (busy_o),
        .done_o  (done_o),
`ifdef MODEXP_ODDN_CHK_EN
        .err_o   (err_o),
`endif
        .c_o     (c_o)
    );

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Reference: square-and-multiply on 64-bit integers, reducing each step.
    function automatic logic [W-1:0] ref_modexp(input logic [W-1:0] m, input logic [W-1:0] e,
                                                 input logic [W-1:0] n);
        longint unsigned r, mm, nn;
        nn = longint'(n);
        mm = longint'(m) % nn;
        r  = 64'd1 % nn;
        for (int i = W - 1; i >= 0; i--) begin
            r = (r * r) % nn;
            if (e[i]) r = (r * mm) % nn;
        end
        return r[W-1:0];
    endfunction

    function automatic logic [W-1:0] ref_r2(input logic [W-1:0] n);
        longint unsigned r, nn;
        nn = longint'(n);
        r  = (64'd1 << W) % nn;
        r  = (r * r) % nn;
        return r[W-1:0];
    endfunction

    function automatic int exp_lat(input logic [W-1:0] e);
        return 34 * (W + 3 + $countones(e)) + 1;
    endfunction

    task automatic launch(input logic [W-1:0] m, input logic [W-1:0] e, input logic [W-1:0] n);
        @(negedge clk_i);
        m_i     = m;
        e_i     = e;
        n_i     = n;
        r2_i    = ref_r2(n);
        start_i = 1'b1;
        @(posedge clk_i);
        #1;
        start_i = 1'b0;
        // Inputs are don't-care once the start is accepted.
        m_i  = $urandom;
        e_i  = $urandom;
        n_i  = $urandom;
        r2_i = $urandom;
    endtask

    // Counts cycles after the start edge until done; optionally pokes start at cycle poke_at.
    task automatic wait_done(input int poke_at, output int lat);
        lat = 0;
        for (int k = 0; k < 6000; k++) begin
            @(negedge clk_i);
            lat++;
            start_i = (lat == poke_at);
            if (lat == poke_at) begin
                m_i  = 32'd7;
                e_i  = 32'd3;
                n_i  = 32'd11;
                r2_i = ref_r2(32'd11);
            end
            if (done_o) break;
        end
        start_i = 1'b0;
    endtask

    task automatic do_case(input string tag, input logic [W-1:0] m, input logic [W-1:0] e,
                           input logic [W-1:0] n, input logic [W-1:0] expc, input int explat,
                           input int poke_at);
        int lat;
        launch(m, e, n);
        wait_done(poke_at, lat);
        check_eq({tag, " done"}, done_o, 1);
        check_eq({tag, " C"}, c_o, expc);
        check_eq({tag, " latency"}, lat, explat);
        @(negedge clk_i);
        check_eq({tag, " busy/done after"}, {busy_o, done_o}, 2'b00);
        check_eq({tag, " C held"}, c_o, expc);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n_done;
        logic [W-1:0] rm, re, rn;

        rst_ni  = 1'b0;
        start_i = 1'b0;
        m_i     = '0;
        e_i     = '0;
        n_i     = '0;
        r2_i    = '0;
        #1;
        check_eq("reset busy/done", {busy_o, done_o}, 2'b00);
        check_eq("reset C", c_o, 0);
`ifdef MODEXP_ODDN_CHK_EN
        check_eq("reset err", err_o, 0);
`endif
        @(negedge clk_i);
        @(negedge clk_i);
        rst_ni = 1'b1;

        do_case("4^13 mod 497", 32'd4, 32'd13, 32'd497, 32'd445, 1293, 0);
        do_case("rsa enc", 32'd65, 32'd17, 32'd3233, 32'd2790, exp_lat(32'd17), 0);
        do_case("rsa dec", 32'd2790, 32'd413, 32'd3233, 32'd65, exp_lat(32'd413), 0);
        do_case("E=0", 32'd123, 32'd0, 32'd3233, 32'd1, exp_lat(32'd0), 0);
        do_case("E=1", 32'd123, 32'd1, 32'd3233, 32'd123, exp_lat(32'd1), 0);
        do_case("M=0", 32'd0, 32'd5, 32'd3233, 32'd0, exp_lat(32'd5), 0);
        do_case("N-1 squared", 32'hFFFF_FFFA, 32'd2, 32'hFFFF_FFFB, 32'd1, exp_lat(32'd2), 0);
`ifdef MODEXP_ODDN_CHK_EN
        check_eq("err clear on odd N", err_o, 0);
`endif

        // Start while busy must be ignored.
        do_case("poke busy", 32'd4, 32'd13, 32'd497, 32'd445, 1293, 300);
        n_done = 0;
        for (int k = 0; k < 80; k++) begin
            @(negedge clk_i);
            if (done_o || busy_o) n_done++;
        end
        check_eq("poke no extra activity", n_done, 0);

        // Abort mid-loop with an asynchronous reset.
        launch(32'd65, 32'd17, 32'd3233);
        repeat (200) @(negedge clk_i);
        check_eq("busy mid-run", busy_o, 1);
        #2;
        rst_ni = 1'b0;
        #1;
        check_eq("abort busy/done", {busy_o, done_o}, 2'b00);
        check_eq("abort C", c_o, 0);
        @(negedge clk_i);
        rst_ni = 1'b1;
        n_done = 0;
        for (int k = 0; k < 100; k++) begin
            @(negedge clk_i);
            if (done_o) n_done++;
        end
        check_eq("abort no done", n_done, 0);
        do_case("after reset", 32'd65, 32'd17, 32'd3233, 32'd2790, exp_lat(32'd17), 0);

        // Random odd moduli, M < N, arbitrary exponents.
        for (int t = 0; t < 5; t++) begin
            rn = $urandom | 32'd1;
            if (rn < 32'd3) rn = 32'd3;
            rm = $urandom % rn;
            re = $urandom;
            do_case($sformatf("rand%0d", t), rm, re, rn, ref_modexp(rm, re, rn), exp_lat(re), 0);
        end

`ifdef MODEXP_ODDN_CHK_EN
        do_case("even N", 32'd65, 32'd17, 32'd3232, 32'd0, 2, 0);
        check_eq("even N err", err_o, 1);
        do_case("odd after err", 32'd65, 32'd17, 32'd3233, 32'd2790, exp_lat(32'd17), 0);
        check_eq("err cleared", err_o, 0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
